// File: rtl/snoop_pkg.sv
// snoop_pkg: MSI/MESI line, bus message and controller FSM encodings (E only stored under SNOOP_MESI_EN)
package snoop_pkg;
   typedef enum logic [1:0] {LS_I = 2'b00, LS_M = 2'b01, LS_S = 2'b10, LS_E = 2'b11} line_state_t;
   typedef enum logic [1:0] {MSG_INV = 2'b00, MSG_RDMISS = 2'b01, MSG_WRMISS = 2'b10, MSG_NONE = 2'b11} bus_msg_t;
   typedef enum logic [2:0] {ST_IDLE, ST_HIT, ST_ARB, ST_WB, ST_MSG, ST_DONE} fsm_state_t;
   function automatic line_state_t next_state_on_snoop(line_state_t s, bus_msg_t m);
      return (s == LS_M || s == LS_E) ? (m == MSG_RDMISS ? LS_S : m == MSG_WRMISS ? LS_I : s)
           : (s == LS_S && (m == MSG_INV || m == MSG_WRMISS)) ? LS_I : s;
   endfunction
endpackage

// File: rtl/snoop_line_array.sv
// snoop_line_array: per-line state+tag registers with a CPU and a snoop read/write port
module snoop_line_array
   import snoop_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int ADDR_W = 8,
   localparam int INDEX_W = $clog2(NUM_LINES),
   localparam int TAG_W = ADDR_W - INDEX_W
) (
   input  logic clock,
   input  logic reset_n,
   input  logic [INDEX_W-1:0] cpu_idx,
   output line_state_t cpu_state,
   output logic [TAG_W-1:0] cpu_tag,
   input  logic cpu_we,
   input  line_state_t cpu_state_wr,
   input  logic [TAG_W-1:0] cpu_tag_wr,
   input  logic [INDEX_W-1:0] snp_idx,
   output line_state_t snp_state,
   output logic [TAG_W-1:0] snp_tag,
   input  logic snp_we,
   input  line_state_t snp_state_wr
);
   line_state_t states [NUM_LINES];
   logic [TAG_W-1:0] tags [NUM_LINES];
   assign cpu_state = states[cpu_idx];
   assign cpu_tag = tags[cpu_idx];
   assign snp_state = states[snp_idx];
   assign snp_tag = tags[snp_idx];
   // CPU write is applied last so it wins on the (bus-excluded) same-line case
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            states[i] <= LS_I;
            tags[i] <= '0;
         end
      end else begin
         if (snp_we) states[snp_idx] <= snp_state_wr;
         if (cpu_we) begin
            states[cpu_idx] <= cpu_state_wr;
            tags[cpu_idx] <= cpu_tag_wr;
         end
      end
endmodule

// File: rtl/snoop_cache_ctrl.sv
// snoop_cache_ctrl: clocked MSI snooping controller for a direct-mapped cache; SNOOP_MESI_EN adds E and bus_shared
module snoop_cache_ctrl
   import snoop_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int ADDR_W = 8,
   localparam int INDEX_W = $clog2(NUM_LINES),
   localparam int TAG_W = ADDR_W - INDEX_W
) (
   input  logic clock,
   input  logic reset_n,
   input  logic cpu_req_valid,
   output logic cpu_req_ready,
   input  logic cpu_req_write,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   output logic cpu_done,
   output logic cpu_hit,
   output logic bus_req,
   input  logic bus_gnt,
`ifdef SNOOP_MESI_EN
   input  logic bus_shared,
`endif
   output logic bus_msg_valid,
   output logic [1:0] bus_msg,
   output logic [ADDR_W-1:0] bus_addr,
   output logic wb_valid,
   output logic [ADDR_W-1:0] wb_addr,
   input  logic wb_ack,
   input  logic snoop_valid,
   input  logic [1:0] snoop_msg,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic snoop_writeback,
   output logic snoop_abort
);
   fsm_state_t state, state_nx;
   logic req_write, pulse, pulse_d, accept, line_hit, hit_ok, snp_hit, cpu_we;
   logic [ADDR_W-1:0] req_addr;
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0] tag, cpu_tag, snp_tag, cpu_tag_wr;
   line_state_t cpu_state, snp_state, cpu_state_wr, snp_state_wr, fill_state;
   snoop_line_array #(.NUM_LINES(NUM_LINES), .ADDR_W(ADDR_W)) u_array (
      .clock(clock),
      .reset_n(reset_n),
      .cpu_idx(idx),
      .cpu_state(cpu_state),
      .cpu_tag(cpu_tag),
      .cpu_we(cpu_we),
      .cpu_state_wr(cpu_state_wr),
      .cpu_tag_wr(cpu_tag_wr),
      .snp_idx(snoop_addr[INDEX_W-1:0]),
      .snp_state(snp_state),
      .snp_tag(snp_tag),
      .snp_we(snp_hit),
      .snp_state_wr(snp_state_wr)
   );
   // The CPU port looks at the incoming request in IDLE, at the registered one afterwards
   assign idx = state == ST_IDLE ? cpu_req_addr[INDEX_W-1:0] : req_addr[INDEX_W-1:0];
   assign tag = state == ST_IDLE ? cpu_req_addr[ADDR_W-1:INDEX_W] : req_addr[ADDR_W-1:INDEX_W];
   assign line_hit = cpu_state != LS_I && cpu_tag == tag;
   assign accept = cpu_req_valid && cpu_req_ready;
`ifdef SNOOP_MESI_EN
   assign hit_ok = line_hit && (!cpu_req_write || cpu_state == LS_M || cpu_state == LS_E);
   assign fill_state = bus_shared ? LS_S : LS_E;
`else
   assign hit_ok = line_hit && (!cpu_req_write || cpu_state == LS_M);
   assign fill_state = LS_S;
`endif
   assign snp_hit = snoop_valid && snp_state != LS_I && snp_tag == snoop_addr[ADDR_W-1:INDEX_W];
   assign snp_state_wr = next_state_on_snoop(snp_state, bus_msg_t'(snoop_msg));
   assign pulse_d = snp_hit && snp_state == LS_M && (snoop_msg == MSG_RDMISS || snoop_msg == MSG_WRMISS);
   assign snoop_writeback = pulse;
   assign snoop_abort = pulse;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= ST_IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: state_nx = accept ? (hit_ok ? ST_HIT : ST_ARB) : ST_IDLE;
         ST_ARB:  if (bus_gnt) state_nx = (cpu_state == LS_M && cpu_tag != tag) ? ST_WB : ST_MSG;
         ST_WB:   if (wb_ack) state_nx = ST_MSG;
         ST_MSG:  state_nx = ST_DONE;
         default: state_nx = ST_IDLE;
      endcase
   end
   always_comb begin
      cpu_req_ready = reset_n && state == ST_IDLE && !snoop_valid;
      cpu_done = state == ST_HIT || state == ST_DONE;
      cpu_hit = state == ST_HIT;
      bus_req = state inside {ST_ARB, ST_WB, ST_MSG};
      bus_msg_valid = state == ST_MSG;
      bus_msg = state != ST_MSG ? MSG_NONE : !req_write ? MSG_RDMISS
              : (cpu_state == LS_S && cpu_tag == tag) ? MSG_INV : MSG_WRMISS;
      bus_addr = state == ST_MSG ? req_addr : '0;
      wb_valid = state == ST_WB;
      wb_addr = state == ST_WB ? {cpu_tag, idx} : '0;
      // Silent E->M on a write hit happens at accept, when no snoop can collide
      cpu_we = (state == ST_WB && wb_ack) || state == ST_MSG
             || (accept && cpu_req_write && line_hit && cpu_state == LS_E);
      cpu_state_wr = state == ST_WB ? LS_I : (state == ST_MSG && !req_write) ? fill_state : LS_M;
      cpu_tag_wr = state == ST_WB ? cpu_tag : tag;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         req_write <= 1'b0;
         req_addr <= '0;
         pulse <= 1'b0;
      end else begin
         pulse <= pulse_d;
         if (accept) begin
            req_write <= cpu_req_write;
            req_addr <= cpu_req_addr;
         end
      end
endmodule
